// File: rtl/alu_chunk_if.sv
// Request/response bundle between EX issue logic and the chunked ALU sequencer.
`timescale 1ns/1ps
interface alu_chunk_if #(
    parameter int unsigned N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   Operation;
    logic         carry_in;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         carry_out;
    logic         zero;

    modport master (
        output in_valid, A, B, Operation, carry_in, flush, out_ready,
        input  in_ready, out_valid, result, carry_out, zero
    );

    modport slave (
        input  in_valid, A, B, Operation, carry_in, flush, out_ready,
        output in_ready, out_valid, result, carry_out, zero
    );
endinterface

// File: rtl/alu_chunk_seq.sv
// Runs an N-bit ALU op over K = N/SLICE cycles on one SLICE-bit slice,
// chaining the carry from the least- to the most-significant chunk.
`timescale 1ns/1ps
module alu_chunk_seq #(
    parameter int unsigned N     = 64,
    parameter int unsigned SLICE = 16
) (
    input logic       clk,
    input logic       rst_n,
    alu_chunk_if.slave bus
);
    localparam int unsigned K  = N / SLICE;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    if (N % SLICE != 0) begin : g_bad_cfg
        $error("alu_chunk_seq: N must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [K-1:0][SLICE-1:0] a_q, a_d;
    logic [K-1:0][SLICE-1:0] b_q, b_d;
    logic [K-1:0][SLICE-1:0] res_q, res_d;
    logic [3:0]              op_q, op_d;
    logic                    creg_q, creg_d;
    logic                    cout_q, cout_d;

    logic [SLICE-1:0]        sl_a, sl_b, sl_res;
    logic [SLICE:0]          sl_sum;
    logic                    sl_carry;

    // Narrow ALU slice; logic ops pass the incoming carry straight through.
    always_comb begin
        sl_a     = a_q[cnt_q];
        sl_b     = b_q[cnt_q];
        sl_sum   = '0;
        sl_res   = '0;
        sl_carry = creg_q;
        case (op_q)
            OP_AND: sl_res = sl_a & sl_b;
            OP_OR:  sl_res = sl_a | sl_b;
            OP_ADD: begin
                sl_sum             = {1'b0, sl_a} + {1'b0, sl_b} + (SLICE+1)'(creg_q);
                {sl_carry, sl_res} = sl_sum;
            end
            OP_SUB: begin
                sl_sum             = {1'b0, sl_a} + {1'b0, ~sl_b} + (SLICE+1)'(creg_q);
                {sl_carry, sl_res} = sl_sum;
            end
            default: ;
        endcase
    end

    // Next-state and datapath update; flush overrides every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        creg_d  = creg_q;
        cout_d  = cout_q;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            creg_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_d     = bus.A;
                        b_d     = bus.B;
                        op_d    = bus.Operation;
                        creg_d  = bus.carry_in;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    res_d[cnt_q] = sl_res;
                    creg_d       = sl_carry;
                    if (cnt_q == CW'(K - 1)) begin
                        cnt_d   = '0;
                        cout_d  = sl_carry;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            creg_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            creg_q  <= creg_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.carry_out = cout_q;
    assign bus.zero      = bus.out_valid & ~(|res_q);
endmodule

// File: tb/tb_alu_chunk_seq.sv
// Directed bench for alu_chunk_seq: vector table plus handshake, flush and reset sequences.
`timescale 1ns/1ps
module tb_alu_chunk_seq;
    localparam int unsigned N = 64;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_chunk_if #(.N(N)) bus ();

    alu_chunk_seq #(.N(N), .SLICE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] res;
        logic        co;
        logic        z;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Issue one request from IDLE and collect the response; call at a negedge.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, output logic [63:0] res, output logic co,
                          output logic z, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.A         = a;
        bus.B         = b;
        bus.Operation = op;
        bus.carry_in  = cin;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = bus.result;
        co  = bus.carry_out;
        z   = bus.zero;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic        c;
        logic        z;
        int          lat;
        int          guard;

        checks   = 0;
        failures = 0;

        vecs[0] = '{4'b0010, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
        vecs[1] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[2] = '{4'b0110, 64'h5, 64'h5, 1'b1, 64'h0, 1'b1, 1'b1};
        vecs[3] = '{4'b0000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b0, 64'hF000_F000_F000_F000, 1'b0, 1'b0};
        vecs[4] = '{4'b0001, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 64'h0FFF_0FFF_0FFF_0FFF, 1'b0, 1'b0};
        vecs[5] = '{4'b0110, 64'h3, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[6] = '{4'b0010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[7] = '{4'b0010, 64'h2, 64'h3, 1'b1, 64'h6, 1'b0, 1'b0};
        vecs[8] = '{4'b0010, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Operation = 4'b0000;
        bus.carry_in  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result",    bus.result,         64'd0);
        check("rst_carry_out", 64'(bus.carry_out), 64'd0);
        check("rst_zero",      64'(bus.zero),      64'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, r, c, z, lat);
            check($sformatf("v%0d_result", i), r, vecs[i].res);
            check($sformatf("v%0d_carry", i), 64'(c), 64'(vecs[i].co));
            check($sformatf("v%0d_zero", i), 64'(z), 64'(vecs[i].z));
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
        end

        // Backpressure: hold out_ready low in DONE with a competing request.
        bus.in_valid  = 1'b1;
        bus.A         = 64'h1234;
        bus.B         = 64'h1111;
        bus.Operation = 4'b0010;
        bus.carry_in  = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("bp_first_result", bus.result, 64'h2345);
        bus.in_valid = 1'b1;
        bus.A        = 64'hDEAD_BEEF_0000_0000;
        bus.B        = 64'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp_hold%0d_ready", i), 64'(bus.in_ready), 64'd0);
            check($sformatf("bp_hold%0d_result", i), bus.result, 64'h2345);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        check("bp_no_accept", 64'(bus.in_ready), 64'd1);

        // Flush on the second RUN cycle, then a clean ADD.
        bus.in_valid  = 1'b1;
        bus.A         = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.B         = 64'h1;
        bus.Operation = 4'b0010;
        bus.carry_in  = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_in_ready",  64'(bus.in_ready),  64'd1);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        guard = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) guard++;
        end
        check("flush_never_valid", 64'(guard), 64'd0);
        run_op(4'b0010, 64'd2, 64'd3, 1'b0, r, c, z, lat);
        check("flush_next_result", r, 64'd5);
        check("flush_next_carry",  64'(c), 64'd0);
        check("flush_next_latency", 64'(lat), 64'd4);

        // Asynchronous reset in the middle of RUN.
        bus.in_valid  = 1'b1;
        bus.A         = 64'h1111_1111_1111_1111;
        bus.B         = 64'h1111_1111_1111_1111;
        bus.Operation = 4'b0010;
        bus.carry_in  = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rrun_busy", 64'(bus.in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rrun_out_valid", 64'(bus.out_valid), 64'd0);
        check("rrun_result",    bus.result,         64'd0);
        check("rrun_carry",     64'(bus.carry_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rrun_in_ready", 64'(bus.in_ready), 64'd1);
        check("rrun_no_valid", 64'(bus.out_valid), 64'd0);
        run_op(4'b0010, 64'd7, 64'd8, 1'b0, r, c, z, lat);
        check("rrun_next_result", r, 64'd15);
        check("rrun_next_zero",   64'(z), 64'd0);
        check("rrun_next_latency", 64'(lat), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
